kitchen_timer_ctrl: RTL and testbench

//   Command sequencer in front of the kitchen-timer countdown FSM. Edge-detects the five front-panel

---
 rtl/kitchen_timer_ctrl_if.sv | 28 ++
 rtl/kitchen_timer_ctrl.sv | 169 ++++++++++++++++
 tb/tb_kitchen_timer_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/kitchen_timer_ctrl_if.sv
// Front-panel / timer-bus bundle for kitchen_timer_ctrl.
// Buttons are levels. A rising level is the request, and the controller always accepts it, so there is no ready. Every output is registered.
`timescale 1ns/1ps
interface kitchen_timer_ctrl_if #(
  parameter int VAL_W = 6
);
  logic             btn_set_min;
  logic             btn_set_sec;
  logic             btn_start;
  logic             btn_pause;
  logic             btn_clear;
  logic [VAL_W-1:0] sw_val;
  logic             time_up;
  logic [12:0]      cmd;
  logic [2:0]       mode;
  logic             alarm;
  logic             err;

  modport master (
    output btn_set_min, btn_set_sec, btn_start, btn_pause, btn_clear, sw_val, time_up,
    input  cmd, mode, alarm, err
  );

  modport slave (
    input  btn_set_min, btn_set_sec, btn_start, btn_pause, btn_clear, sw_val, time_up,
    output cmd, mode, alarm, err
  );
endinterface

// File: rtl/kitchen_timer_ctrl.sv
// Command sequencer for the kitchen-timer countdown: button edge detect, value clamp, 13-bit command bus, alarm phase.
// Optional macro AUTO_RESTART_EN: alarm expiry re-commits the last loaded time and resumes RUN instead of clearing.
`timescale 1ns/1ps
module kitchen_timer_ctrl #(
  parameter int VAL_W        = 6,
  parameter int MAX_VAL      = 59,
  parameter int ALARM_CYCLES = 50
) (
  input logic                 clk,
  input logic                 rst,
  kitchen_timer_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_ALARM = 3'd4
  } state_t;

  localparam int CW = $clog2(ALARM_CYCLES + 1);

  state_t           state_q, state_d;
  logic [4:0]       btn, prev_q, press_q;
  logic [VAL_W-1:0] val_q, val_d, clamped;
  logic             ld_sec_q, ld_sec_d, ld_min_q, ld_min_d;
  logic             run_q, run_d, hold_q, hold_d;
  logic             clr_q, clr_d, commit_q, commit_d;
  logic             alarm_q, alarm_d, err_q, err_d;
  logic             loaded_q, loaded_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             p_clr, p_pause, p_start, p_min, p_sec, any_press;

  // Bit order matches the same-cycle priority, with clear as the MSB.
  assign btn = {bus.btn_clear, bus.btn_pause, bus.btn_start, bus.btn_set_min, bus.btn_set_sec};

  assign p_clr     = press_q[4];
  assign p_pause   = press_q[3] & ~press_q[4];
  assign p_start   = press_q[2] & ~|press_q[4:3];
  assign p_min     = press_q[1] & ~|press_q[4:2];
  assign p_sec     = press_q[0] & ~|press_q[4:1];
  assign any_press = |press_q;

  assign clamped = (bus.sw_val > VAL_W'(MAX_VAL)) ? VAL_W'(MAX_VAL) : bus.sw_val;

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    ld_sec_d = 1'b0;
    ld_min_d = 1'b0;
    clr_d    = 1'b0;
    commit_d = 1'b0;
    err_d    = 1'b0;
    run_d    = run_q;
    hold_d   = hold_q;
    alarm_d  = alarm_q;
    loaded_d = loaded_q;
    cnt_d    = cnt_q;
    // A press that dismisses the alarm is consumed by the clear and is not executed.
    if (p_clr || (state_q == S_ALARM && any_press)) begin
      clr_d    = 1'b1;
      run_d    = 1'b0;
      hold_d   = 1'b0;
      alarm_d  = 1'b0;
      loaded_d = 1'b0;
      state_d  = S_IDLE;
    end else if (state_q == S_ALARM) begin
      if (cnt_q == CW'(ALARM_CYCLES - 1)) begin
`ifdef AUTO_RESTART_EN
        alarm_d  = 1'b0;
        commit_d = 1'b1;
        run_d    = 1'b1;
        state_d  = S_RUN;
`else
        clr_d    = 1'b1;
        run_d    = 1'b0;
        hold_d   = 1'b0;
        alarm_d  = 1'b0;
        loaded_d = 1'b0;
        state_d  = S_IDLE;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE, S_SET: begin
          if (p_start) begin
            if (state_q == S_SET && loaded_q) begin
              commit_d = 1'b1;
              run_d    = 1'b1;
              state_d  = S_RUN;
            end else begin
              err_d = 1'b1;
            end
          end else if (p_min || p_sec) begin
            val_d    = clamped;
            ld_min_d = p_min;
            ld_sec_d = p_sec;
            loaded_d = 1'b1;
            state_d  = S_SET;
          end
        end
        S_RUN: begin
          // When the timer expires, that takes precedence over a pause arriving in the same cycle.
          if (bus.time_up) begin
            run_d   = 1'b0;
            alarm_d = 1'b1;
            cnt_d   = '0;
            state_d = S_ALARM;
          end else if (p_pause) begin
            run_d   = 1'b0;
            hold_d  = 1'b1;
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (p_start) begin
            hold_d  = 1'b0;
            run_d   = 1'b1;
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prev_q   <= '0;
      press_q  <= '0;
      val_q    <= '0;
      ld_sec_q <= 1'b0;
      ld_min_q <= 1'b0;
      run_q    <= 1'b0;
      hold_q   <= 1'b0;
      clr_q    <= 1'b0;
      commit_q <= 1'b0;
      alarm_q  <= 1'b0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= btn;
      press_q  <= btn & ~prev_q;
      val_q    <= val_d;
      ld_sec_q <= ld_sec_d;
      ld_min_q <= ld_min_d;
      run_q    <= run_d;
      hold_q   <= hold_d;
      clr_q    <= clr_d;
      commit_q <= commit_d;
      alarm_q  <= alarm_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.cmd   = {commit_q, clr_q, 1'b0, hold_q, run_q, ld_min_q, ld_sec_q, val_q};
  assign bus.mode  = state_q;
  assign bus.alarm = alarm_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// Scoreboard bench for kitchen_timer_ctrl: the driver pushes the reference-model response for each edge, and a negedge monitor pops and compares it.
`timescale 1ns/1ps
module tb_kitchen_timer_ctrl;
  localparam int AC   = 50;
  localparam int MAXV = 59;
  localparam int W    = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  kitchen_timer_ctrl_if #(.VAL_W(6)) bus();

  kitchen_timer_ctrl #(.VAL_W(6), .MAX_VAL(MAXV), .ALARM_CYCLES(AC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 set, 2 run, 3 pause, 4 alarm; m_left is the number of alarm cycles still owed
  int   m_mode, m_val, m_left;
  logic m_run, m_hold, m_alarm, m_loaded;
  logic m_ldmin, m_ldsec, m_clr, m_commit, m_err;
  logic [4:0] m_prev, m_press;

  function automatic logic [W-1:0] model_out();
    logic [12:0] c;
    c = {m_commit, m_clr, 1'b0, m_hold, m_run, m_ldmin, m_ldsec, 6'(m_val)};
    return {c, 3'(m_mode), m_alarm, m_err};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_val = 0; m_left = 0;
    m_run = 0; m_hold = 0; m_alarm = 0; m_loaded = 0;
    m_ldmin = 0; m_ldsec = 0; m_clr = 0; m_commit = 0; m_err = 0;
    m_prev = '0; m_press = '0;
  endtask

  task automatic model_clear();
    m_clr = 1; m_run = 0; m_hold = 0; m_alarm = 0; m_loaded = 0; m_mode = 0;
  endtask

  task automatic model_load(int win, int sw);
    m_val = (sw > MAXV) ? MAXV : sw;
    if (win == 1) m_ldmin = 1; else m_ldsec = 1;
    m_loaded = 1;
    m_mode = 1;
  endtask

  // One clock edge: act on the press seen at the previous edge, then record the new one.
  task automatic model_step(logic [4:0] b, int sw, logic tu);
    int win;
    m_ldmin = 0; m_ldsec = 0; m_clr = 0; m_commit = 0; m_err = 0;
    win = -1;
    for (int i = 4; i >= 0; i--) if (m_press[i] && win < 0) win = i;
    if (win == 4 || (m_mode == 4 && win >= 0)) begin
      model_clear();
    end else if (m_mode == 4) begin
      if (m_left == 1) begin
`ifdef AUTO_RESTART_EN
        m_alarm = 0; m_commit = 1; m_run = 1; m_mode = 2;
`else
        model_clear();
`endif
      end else begin
        m_left--;
      end
    end else begin
      case (m_mode)
        0: begin
          if (win == 2) m_err = 1;
          else if (win == 0 || win == 1) model_load(win, sw);
        end
        1: begin
          if (win == 2) begin
            if (m_loaded) begin m_commit = 1; m_run = 1; m_mode = 2; end
            else m_err = 1;
          end else if (win == 0 || win == 1) model_load(win, sw);
        end
        2: begin
          if (tu) begin m_run = 0; m_alarm = 1; m_left = AC; m_mode = 4; end
          else if (win == 3) begin m_run = 0; m_hold = 1; m_mode = 3; end
        end
        3: begin
          if (win == 2) begin m_hold = 0; m_run = 1; m_mode = 2; end
        end
        default: ;
      endcase
    end
    m_press = b & ~m_prev;
    m_prev  = b;
  endtask

  // ---------------- checking ----------------
  function automatic logic [W-1:0] dut_out();
    return {bus.cmd, bus.mode, bus.alarm, bus.err};
  endfunction

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t got cmd=%h mode=%0d alarm=%b err=%b want cmd=%h mode=%0d alarm=%b err=%b",
               name, $time, act[17:5], act[4:2], act[1], act[0], want[17:5], want[4:2], want[1], want[0]);
    end
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", dut_out(), e);
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1. Applies the inputs for the coming edge and queues the model response.
  task automatic cyc(logic [4:0] b, int sw, logic tu);
    {bus.btn_clear, bus.btn_pause, bus.btn_start, bus.btn_set_min, bus.btn_set_sec} = b;
    bus.sw_val  = 6'(sw);
    bus.time_up = tu;
    @(posedge clk);
    model_step(b, sw, tu);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic idle(int n, logic tu = 1'b0);
    for (int i = 0; i < n; i++) cyc(5'b0, 0, tu);
  endtask

  task automatic press(logic [4:0] b, int sw = 0, logic tu = 1'b0);
    cyc(b, sw, tu);
    cyc(5'b0, sw, tu);
  endtask

  task automatic do_reset();
    {bus.btn_clear, bus.btn_pause, bus.btn_start, bus.btn_set_min, bus.btn_set_sec} = 5'b0;
    bus.sw_val  = '0;
    bus.time_up = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("reset_async", dut_out(), '0);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      exp_q.push_back(model_out());
    end
    #1 check("reset_held", dut_out(), '0);
    rst = 1'b0;
  endtask

  localparam logic [4:0] B_SEC = 5'b00001, B_MIN = 5'b00010, B_START = 5'b00100,
                         B_PAUSE = 5'b01000, B_CLR = 5'b10000;

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [4:0] b, b_prev;
    logic       tu;
    int         r;
    model_reset();
    do_reset();

    press(B_START); idle(3);                              // start with nothing loaded
    press(B_MIN, 5); press(B_SEC, 40); press(B_START); idle(4);
    press(B_PAUSE); idle(3);
    press(B_START); idle(3);                              // resume without commit
    press(B_CLR | B_START); idle(3);                      // clear wins
    for (int i = 0; i < 20; i++) cyc(B_SEC, 63, 1'b0);    // held button, clamp to 59
    idle(3);
    press(B_START); idle(3);
    for (int i = 0; i < AC + 6; i++) cyc(5'b0, 0, 1'b1);  // expiry path
    idle(6);
    press(B_CLR); idle(2);

    press(B_MIN, 1); press(B_START); idle(2);
    idle(5, 1'b1);
    press(B_PAUSE); idle(4);                              // press dismisses alarm

    press(B_SEC, 0, 1'b1); press(B_START, 0, 1'b1); idle(4, 1'b1);  // time_up already high
    press(B_CLR); idle(2);

    press(B_MIN, 2); press(B_START); press(B_PAUSE);
    idle(4, 1'b1);                                        // time_up ignored in pause
    press(B_SEC, 9); press(B_MIN, 9); idle(2);            // set ignored in pause
    press(B_CLR); idle(2);

    press(B_MIN, 3); press(B_START); idle(2);
    do_reset();                                           // reset mid-operation
    idle(3);

    b_prev = '0;
    tu = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 30)      b = b_prev;
      else if (r < 42) b = 5'(1 << $urandom_range(0, 3));
      else if (r < 44) b = B_CLR;
      else if (r < 47) b = 5'($urandom_range(0, 31));
      else             b = '0;
      if ($urandom_range(0, 24) == 0) tu = ~tu;
      cyc(b, $urandom_range(0, 63), tu);
      b_prev = b;
    end
    idle(4);

    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain queue left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
